// File: rtl/module_instruction_fetch.sv
// Instruction fetch stage: owns the PC, issues word reads under a credit limit and
// buffers in-order responses in a prefetch FIFO feeding the decoder.
module module_instruction_fetch #(
   parameter int unsigned              INSTRUCTION_WIDTH = 32,
   parameter int unsigned              ADDRESS_WIDTH     = 32,
   parameter logic [ADDRESS_WIDTH-1:0] RESET_PC          = '0,
   parameter int unsigned              FIFO_DEPTH        = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   output logic                         imem_req,
   output logic [ADDRESS_WIDTH-1:0]     imem_addr,
   input  logic                         imem_gnt,
   input  logic                         imem_rvalid,
   input  logic [INSTRUCTION_WIDTH-1:0] imem_rdata,
   input  logic                         redirect,
   input  logic [ADDRESS_WIDTH-1:0]     redirect_pc,
   output logic                         instr_valid,
   input  logic                         instr_ready,
   output logic [INSTRUCTION_WIDTH-1:0] instruction,
   output logic [ADDRESS_WIDTH-1:0]     instr_pc
);

   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW:0] DepthW = (CW + 1)'(FIFO_DEPTH);
   localparam logic [ADDRESS_WIDTH-1:0] Step = ADDRESS_WIDTH'(4);

   typedef logic [CW-1:0] cnt_t;
   typedef logic [PW-1:0] ptr_t;

   logic [ADDRESS_WIDTH-1:0]     pc_q, pc_d, resp_pc_q, resp_pc_d;
   cnt_t                         count_q, count_d, outstanding_q, outstanding_d;
   cnt_t                         drop_q, drop_d, out_acc, drop_acc;
   ptr_t                         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic                         run_q;
   logic [INSTRUCTION_WIDTH-1:0] fifo_instr_q [FIFO_DEPTH];
   logic [ADDRESS_WIDTH-1:0]     fifo_pc_q    [FIFO_DEPTH];
   logic [CW:0]                  credit_sum;
   logic                         issue, resp_drop, push, pop;

   // run_q holds requests off while reset is asserted without a path from rst_n.
   assign credit_sum = {1'b0, outstanding_q} + {1'b0, drop_q} + {1'b0, count_q};
   assign imem_req   = run_q && (credit_sum < DepthW);
   assign imem_addr  = pc_q;
   assign issue      = imem_req && imem_gnt;
   assign resp_drop  = imem_rvalid && (drop_q != '0);
   assign push       = imem_rvalid && (drop_q == '0) && (outstanding_q != '0);

   assign instr_valid = (count_q != '0);
   assign pop         = instr_valid && instr_ready;
   assign instruction = instr_valid ? fifo_instr_q[rd_ptr_q] : '0;
   assign instr_pc    = instr_valid ? fifo_pc_q[rd_ptr_q] : '0;

   always_comb begin
      out_acc       = outstanding_q + cnt_t'(issue) - cnt_t'(push);
      drop_acc      = drop_q - cnt_t'(resp_drop);
      pc_d          = issue ? pc_q + Step : pc_q;
      resp_pc_d     = push ? resp_pc_q + Step : resp_pc_q;
      count_d       = count_q + cnt_t'(push) - cnt_t'(pop);
      wr_ptr_d      = push ? wr_ptr_q + ptr_t'(1) : wr_ptr_q;
      rd_ptr_d      = pop ? rd_ptr_q + ptr_t'(1) : rd_ptr_q;
      outstanding_d = out_acc;
      drop_d        = drop_acc;
      if (redirect) begin
         // Everything still in flight, including a grant this cycle, must be discarded.
         pc_d          = {redirect_pc[ADDRESS_WIDTH-1:2], 2'b00};
         resp_pc_d     = {redirect_pc[ADDRESS_WIDTH-1:2], 2'b00};
         count_d       = '0;
         wr_ptr_d      = '0;
         rd_ptr_d      = '0;
         drop_d        = out_acc + drop_acc;
         outstanding_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q          <= RESET_PC;
         resp_pc_q     <= RESET_PC;
         count_q       <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         outstanding_q <= '0;
         drop_q        <= '0;
         run_q         <= 1'b0;
      end else begin
         pc_q          <= pc_d;
         resp_pc_q     <= resp_pc_d;
         count_q       <= count_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         outstanding_q <= outstanding_d;
         drop_q        <= drop_d;
         run_q         <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_instr_q[wr_ptr_q] <= imem_rdata;
         fifo_pc_q[wr_ptr_q]    <= resp_pc_q;
      end
   end

   // A response with nothing in flight breaks the memory protocol; its data is ignored.
   a_resp_expected : assert property (@(posedge clk) disable iff (!rst_n)
      imem_rvalid |-> ((outstanding_q != '0) || (drop_q != '0)));

endmodule
